// File: rtl/mips_mdu.sv
// Iterative MIPS multiply/divide unit with HI/LO; one result bit per cycle, WIDTH+1 busy cycles per MULT/DIV.
// No backpressure beyond busy: start is ignored while busy, MTHI/MTLO complete in the accept cycle.
module mips_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   aorig_q, aorig_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_signed = ~op[0];
  assign mag_a     = (is_signed && a[WIDTH-1]) ? ('0 - a) : a;
  assign mag_b     = (is_signed && b[WIDTH-1]) ? ('0 - b) : b;

  // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_add = acc_q[0] ? opnd_q : '0;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};

  // Divide: dividend shifts out of acc[WIDTH-1:0] while quotient bits shift in; borrow in bit WIDTH.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_bit   = ~div_diff[WIDTH];

  assign prod_fix = neg_q  ? ('0 - acc_q) : acc_q;
  assign quo_fix  = neg_q  ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? ('0 - rem_q) : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    rem_d    = rem_q;
    aorig_d  = aorig_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            3'b100: hi_d = a;
            3'b101: lo_d = a;
            3'b000, 3'b001, 3'b010, 3'b011: begin
              is_div_d = op[1];
              neg_d    = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg_d   = is_signed && a[WIDTH-1];
              dz_d     = op[1] && (b == '0);
              aorig_d  = a;
              rem_d    = '0;
              cnt_d    = CW'(WIDTH-1);
              state_d  = S_RUN;
              if (op[1]) begin
                acc_d  = {{WIDTH{1'b0}}, mag_a};
                opnd_d = mag_b;
              end else begin
                acc_d  = {{WIDTH{1'b0}}, mag_b};
                opnd_d = mag_a;
              end
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            rem_d = div_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_bit};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (dz_q) begin
            lo_d = '1;
            hi_d = aorig_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      rem_q    <= '0;
      aorig_q  <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      rem_q    <= rem_d;
      aorig_q  <= aorig_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_mdu.sv
// Directed bench for mips_mdu: a 32-bit and an 8-bit instance against hand-computed results.
module tb_mips_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic        start8, flush8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_mdu #(.WIDTH(32)) u_mdu32 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mips_mdu #(.WIDTH(8)) u_mdu8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic op32(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] h0, l0;
    int bc;
    bit dn, held;
    @(negedge clk);
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    bc = 0; dn = 1'b0; held = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (done) begin dn = 1'b1; break; end
      if (busy) bc++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_done"}, dn, 1);
    chk({tag, "_busy"}, bc, 33);
    chk({tag, "_hold"}, held, 1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  task automatic op8t(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] exp_hi, input logic [7:0] exp_lo);
    int bc;
    bit dn;
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
    bc = 0; dn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin dn = 1'b1; break; end
      if (busy8) bc++;
      @(negedge clk);
    end
    chk({tag, "_done"}, dn, 1);
    chk({tag, "_busy"}, bc, 9);
    chk({tag, "_hi"}, hi8, exp_hi);
    chk({tag, "_lo"}, lo8, exp_lo);
  endtask

  initial begin
    bit dn;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = 3'b000; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    op32("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    @(negedge clk);
    chk("done_clears", done, 0);
    op32("mult_neg", 3'b000, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB);
    op32("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op32("div_negb", 3'b010, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    op32("div_min", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    op32("divu_zero", 3'b011, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
    op32("div_zero", 3'b010, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    op32("divu_rem", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);

    // Reserved opcodes leave everything alone.
    @(negedge clk); start = 1'b1; op = 3'b110; a = 32'h1; b = 32'h1;
    @(negedge clk); op = 3'b111;
    @(negedge clk); start = 1'b0;
    chk("rsvd_busy", busy, 0);
    chk("rsvd_hi", hi, 32'd2);
    chk("rsvd_lo", lo, 32'd14);

    // MTHI then MTLO on consecutive cycles.
    start = 1'b1; op = 3'b100; a = 32'hAA;
    @(negedge clk); op = 3'b101; a = 32'h55;
    @(negedge clk); start = 1'b0;
    chk("mt_hi", hi, 32'hAA);
    chk("mt_lo", lo, 32'h55);
    chk("mt_busy", busy, 0);
    chk("mt_done", done, 0);

    // Flush in IDLE suppresses both a move and a multiply.
    start = 1'b1; op = 3'b100; a = 32'h77; flush = 1'b1;
    @(negedge clk); op = 3'b000; a = 32'd5; b = 32'd5;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    chk("flush_idle_hi", hi, 32'hAA);
    chk("flush_idle_busy", busy, 0);

    // Flush ten cycles into RUN.
    start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_run_busy", busy, 0);
    dn = 1'b0;
    repeat (40) begin
      if (done) dn = 1'b1;
      @(negedge clk);
    end
    chk("flush_run_done", dn, 0);
    chk("flush_run_hi", hi, 32'hAA);
    chk("flush_run_lo", lo, 32'h55);

    // Flush in the FIX cycle (33rd busy cycle).
    start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (32) @(negedge clk);
    chk("fix_busy_before", busy, 1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_fix_busy", busy, 0);
    chk("flush_fix_done", done, 0);
    chk("flush_fix_lo", lo, 32'h55);

    // Asynchronous reset mid-RUN.
    start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    @(negedge clk); rst_n = 1'b1;

    // A start while busy is dropped, not queued.
    @(negedge clk); start = 1'b1; op = 3'b001; a = 32'd6; b = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd9; b = 32'd3;
    @(negedge clk); start = 1'b0;
    dn = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin dn = 1'b1; break; end
      @(negedge clk);
    end
    chk("ign_done", dn, 1);
    chk("ign_hi", hi, 0);
    chk("ign_lo", lo, 32'd42);
    @(negedge clk);
    chk("ign_idle", busy, 0);

    op8t("w8_multu", 3'b001, 8'hFF, 8'h02, 8'h01, 8'hFE);
    op8t("w8_mult_min", 3'b000, 8'h80, 8'h80, 8'h40, 8'h00);
    op8t("w8_div_min", 3'b010, 8'h80, 8'hFF, 8'h00, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
